// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// State/owner encodings and default bus widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating wait-cycle counter for the memory arbiter.
// Flags expiry on the last cycle before a timeout completes.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST =
    (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);
  localparam logic [W-1:0] TOP = '1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && cnt != TOP) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && run && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store.
// D-side priority with a streak limit guarding I-side starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err_sticky
);

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  state_t     state;
  owner_t     lock_own;
  owner_t     win_own;
  logic       lock;
  logic       win_vld;
  logic       is_store;
  logic       gnt;
  logic       expire;
  logic [3:0] streak;

  // Reset also masks the request path so m_req/gnt read 0 under rst.
  always_comb begin
    win_vld = 1'b0;
    win_own = OWN_I;
    if (!rst && state == IDLE) begin
      if (lock) begin
        win_vld = 1'b1;
        win_own = lock_own;
      end else if (d_req && !(i_req && streak == MAX_S)) begin
        win_vld = 1'b1;
        win_own = OWN_D;
      end else if (i_req) begin
        win_vld = 1'b1;
        win_own = OWN_I;
      end
    end
  end

  assign m_req   = win_vld;
  assign m_we    = win_vld && win_own == OWN_D && d_we;
  assign m_addr  = !win_vld ? '0 :
                   (win_own == OWN_D) ? d_addr : i_addr;
  assign m_wdata = (win_vld && win_own == OWN_D) ? d_wdata : '0;
  assign i_gnt   = win_vld && win_own == OWN_I && m_gnt;
  assign d_gnt   = win_vld && win_own == OWN_D && m_gnt;
  assign gnt     = i_gnt || d_gnt;

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clear (gnt),
    .run   (state != IDLE),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lock       <= 1'b0;
      lock_own   <= OWN_I;
      is_store   <= 1'b0;
      streak     <= '0;
      i_rvalid   <= 1'b0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      i_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt) begin
            state    <= d_gnt ? WAIT_D : WAIT_I;
            lock     <= 1'b0;
            is_store <= d_gnt && d_we;
            if (d_gnt && i_req)
              streak <= (streak == MAX_S) ? streak : streak + 4'd1;
            else
              streak <= '0;
          end else if (win_vld) begin
            lock     <= 1'b1;
            lock_own <= win_own;
          end
        end
        WAIT_I: begin
          if (m_rvalid) begin
            state    <= IDLE;
            i_rvalid <= 1'b1;
            i_rdata  <= m_rdata;
          end else if (expire) begin
            state      <= IDLE;
            i_rvalid   <= 1'b1;
            i_err      <= 1'b1;
            err_sticky <= 1'b1;
          end
        end
        WAIT_D: begin
          if (m_rvalid) begin
            state    <= IDLE;
            d_rvalid <= 1'b1;
            d_rdata  <= is_store ? '0 : m_rdata;
          end else if (expire) begin
            state      <= IDLE;
            d_rvalid   <= 1'b1;
            d_err      <= 1'b1;
            err_sticky <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
